lc4_ss_dispatch: RTL and testbench

Two-wide decode/issue buffer for the superscalar LC4 pipe. It sits directly upstream of the dual-pipe register file. Each cycle it accepts a fetched instruction pair, checks intra-pair hazards, and either issues both instructions or splits the pair across two cycles. It drives the four regfile read selectors and the per-pipe issue bundles into execute.

---
 rtl/lc4_ss_pkg.sv | 42 ++++
 rtl/lc4_ss_dispatch_if.sv | 36 +++
 rtl/lc4_ss_hazard.sv | 31 +++
 rtl/lc4_ss_dispatch.sv | 179 +++++++++++++++++
 tb/tb_lc4_ss_dispatch.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc4_ss_pkg.sv
// lc4_ss_pkg: shared definitions for the LC4 superscalar dispatch buffer.
//   - FSM state encoding (EMPTY / ONE / PAIR)
//   - packed slot layout: {pc, insn, rs, rt, rd, rs_re, rt_re, rd_we, is_mem, is_br}
//     with pc/insn n bits wide and a fixed 14-bit control tail at the bottom
//   - hazard reason breakdown struct used for debug visibility
package lc4_ss_pkg;

  typedef logic [1:0] ss_state_t;

  localparam ss_state_t EMPTY = 2'd0;
  localparam ss_state_t ONE   = 2'd1;
  localparam ss_state_t PAIR  = 2'd2;

  // Control tail offsets (LSB first). insn sits directly above the tail,
  // pc directly above insn.
  localparam int OFF_IS_BR  = 0;
  localparam int OFF_IS_MEM = 1;
  localparam int OFF_RD_WE  = 2;
  localparam int OFF_RT_RE  = 3;
  localparam int OFF_RS_RE  = 4;
  localparam int OFF_RD     = 5;
  localparam int OFF_RT     = 8;
  localparam int OFF_RS     = 11;
  localparam int CTRL_W     = 14;
  localparam int OFF_INSN   = CTRL_W;

  function automatic int slot_w(input int n);
    return 2 * n + CTRL_W;
  endfunction

  function automatic int off_pc(input int n);
    return OFF_INSN + n;
  endfunction

  typedef struct packed {
    logic raw_rs;   // S1 reads rs that S0 writes
    logic raw_rt;   // S1 reads rt that S0 writes
    logic mem_mem;  // both slots touch memory (single mem port)
    logic br_s0;    // older slot is a control transfer
  } hz_reason_t;

endpackage

// File: rtl/lc4_ss_dispatch_if.sv
// lc4_ss_dispatch_if: fetch -> dispatch instruction-pair handshake.
//   master modport: fetch side (drives i_*, observes o_ready)
//   slave  modport: dispatch side
// Handshake: a pair transfers on a clock edge where i_valid && o_ready
// (and the global write enable is high); fetch must hold the pair
// stable while i_valid is high and o_ready is low.
interface lc4_ss_dispatch_if #(
  parameter int n = 16
);
  logic         i_valid;
  logic         o_ready;
  logic [n-1:0] i_pc_A,   i_pc_B;
  logic [n-1:0] i_insn_A, i_insn_B;
  logic [2:0]   i_rs_A, i_rt_A, i_rd_A;
  logic [2:0]   i_rs_B, i_rt_B, i_rd_B;
  logic         i_rs_re_A, i_rt_re_A, i_rd_we_A;
  logic         i_rs_re_B, i_rt_re_B, i_rd_we_B;
  logic         i_is_mem_A, i_is_br_A;
  logic         i_is_mem_B, i_is_br_B;

  modport master (
    output i_valid, i_pc_A, i_pc_B, i_insn_A, i_insn_B,
           i_rs_A, i_rt_A, i_rd_A, i_rs_B, i_rt_B, i_rd_B,
           i_rs_re_A, i_rt_re_A, i_rd_we_A, i_rs_re_B, i_rt_re_B, i_rd_we_B,
           i_is_mem_A, i_is_br_A, i_is_mem_B, i_is_br_B,
    input  o_ready
  );

  modport slave (
    input  i_valid, i_pc_A, i_pc_B, i_insn_A, i_insn_B,
           i_rs_A, i_rt_A, i_rd_A, i_rs_B, i_rt_B, i_rd_B,
           i_rs_re_A, i_rt_re_A, i_rd_we_A, i_rs_re_B, i_rt_re_B, i_rd_we_B,
           i_is_mem_A, i_is_br_A, i_is_mem_B, i_is_br_B,
    output o_ready
  );
endinterface

// File: rtl/lc4_ss_hazard.sv
// lc4_ss_hazard: purely combinational intra-pair hazard check.
//   inputs : S0 (older) destination/mem/branch fields, S1 (younger) sources/mem
//   outputs: conflict (S1 must not issue alongside S0), reason breakdown
// A shared destination (WAW) is deliberately not a conflict: the regfile
// gives pipe B the write priority, which matches program order.
module lc4_ss_hazard
  import lc4_ss_pkg::*;
(
  input  logic [2:0] s0_rd,
  input  logic       s0_rd_we,
  input  logic       s0_is_mem,
  input  logic       s0_is_br,
  input  logic [2:0] s1_rs,
  input  logic       s1_rs_re,
  input  logic [2:0] s1_rt,
  input  logic       s1_rt_re,
  input  logic       s1_is_mem,
  output logic       conflict,
  output hz_reason_t reason
);

  always_comb begin
    reason         = '0;
    reason.raw_rs  = s1_rs_re && s0_rd_we && (s1_rs == s0_rd);
    reason.raw_rt  = s1_rt_re && s0_rd_we && (s1_rt == s0_rd);
    reason.mem_mem = s0_is_mem && s1_is_mem;
    reason.br_s0   = s0_is_br;
    conflict       = |reason;
  end

endmodule

// File: rtl/lc4_ss_dispatch.sv
// lc4_ss_dispatch: two-wide decode/issue buffer for the superscalar LC4 pipe.
//   clk, rst (async, active-low), gwe (global write enable; state holds at 0)
//   fetch           : lc4_ss_dispatch_if.slave, pair handshake from fetch
//   i_stall/i_flush : downstream load-use stall / mispredict flush
//   o_issue_valid_* : per-pipe issue strobes; o_pc/insn/rd/rd_we_* bundles
//   o_rs/rt_*       : regfile read selectors (A follows S0, B follows S1)
//   o_pair_cnt/o_split_cnt : issue statistics, present only when the
//                     LC4_SS_STATS_EN macro is defined (tied to 0 otherwise)
//   o_dbg_state/o_dbg_conflict/o_dbg_flags : FSM state, hazard reasons and
//                     slot control flags {S0 rs_re,rt_re,rd_we,mem,br, S1 ...}
// Bundle and selector outputs of a slot that holds nothing drive 0.
module lc4_ss_dispatch
  import lc4_ss_pkg::*;
#(
  parameter int n      = 16,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gwe,
  lc4_ss_dispatch_if.slave  fetch,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_issue_valid_A,
  output logic              o_issue_valid_B,
  output logic [n-1:0]      o_pc_A,
  output logic [n-1:0]      o_pc_B,
  output logic [n-1:0]      o_insn_A,
  output logic [n-1:0]      o_insn_B,
  output logic [2:0]        o_rd_A,
  output logic [2:0]        o_rd_B,
  output logic              o_rd_we_A,
  output logic              o_rd_we_B,
  output logic [2:0]        o_rs_A,
  output logic [2:0]        o_rt_A,
  output logic [2:0]        o_rs_B,
  output logic [2:0]        o_rt_B,
  output logic [STAT_W-1:0] o_pair_cnt,
  output logic [STAT_W-1:0] o_split_cnt,
  output logic [1:0]        o_dbg_state,
  output logic [3:0]        o_dbg_conflict,
  output logic [9:0]        o_dbg_flags
);

  localparam int SW     = slot_w(n);
  localparam int OFF_PC = off_pc(n);

  ss_state_t   state_q, state_d;
  logic [SW-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [SW-1:0] in_a, in_b;

  logic       s0_vld, s1_vld;
  logic       conflict, pair_conflict;
  hz_reason_t reason;

  assign in_a = {fetch.i_pc_A, fetch.i_insn_A, fetch.i_rs_A, fetch.i_rt_A,
                 fetch.i_rd_A, fetch.i_rs_re_A, fetch.i_rt_re_A,
                 fetch.i_rd_we_A, fetch.i_is_mem_A, fetch.i_is_br_A};
  assign in_b = {fetch.i_pc_B, fetch.i_insn_B, fetch.i_rs_B, fetch.i_rt_B,
                 fetch.i_rd_B, fetch.i_rs_re_B, fetch.i_rt_re_B,
                 fetch.i_rd_we_B, fetch.i_is_mem_B, fetch.i_is_br_B};

  assign s0_vld        = (state_q == ONE) || (state_q == PAIR);
  assign s1_vld        = (state_q == PAIR);
  assign pair_conflict = s1_vld && conflict;

  lc4_ss_hazard u_hazard (
    .s0_rd     (s0_q[OFF_RD +: 3]),
    .s0_rd_we  (s0_q[OFF_RD_WE]),
    .s0_is_mem (s0_q[OFF_IS_MEM]),
    .s0_is_br  (s0_q[OFF_IS_BR]),
    .s1_rs     (s1_q[OFF_RS +: 3]),
    .s1_rs_re  (s1_q[OFF_RS_RE]),
    .s1_rt     (s1_q[OFF_RT +: 3]),
    .s1_rt_re  (s1_q[OFF_RT_RE]),
    .s1_is_mem (s1_q[OFF_IS_MEM]),
    .conflict  (conflict),
    .reason    (reason)
  );

  // State register (FSM state plus the two slots it qualifies).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      s0_q    <= '0;
      s1_q    <= '0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
    end
  end

  // Next-state logic. Flush beats stall beats everything else. A drained
  // buffer (nothing left behind after this cycle's issue) refills directly,
  // giving single-cycle accept-to-issue latency.
  always_comb begin
    state_d = state_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    if (gwe) begin
      if (i_flush) begin
        state_d = EMPTY;
      end else if (!i_stall) begin
        if (pair_conflict) begin
          s0_d    = s1_q;
          state_d = ONE;
        end else if (fetch.i_valid) begin
          s0_d    = in_a;
          s1_d    = in_b;
          state_d = PAIR;
        end else begin
          state_d = EMPTY;
        end
      end
    end
  end

  // Output logic.
  always_comb begin
    o_issue_valid_A = s0_vld && !i_stall;
    o_issue_valid_B = s1_vld && !conflict && !i_stall;
    fetch.o_ready   = !i_stall && !i_flush && !pair_conflict;

    o_pc_A    = s0_vld ? s0_q[OFF_PC +: n]   : '0;
    o_insn_A  = s0_vld ? s0_q[OFF_INSN +: n] : '0;
    o_rd_A    = s0_vld ? s0_q[OFF_RD +: 3]   : '0;
    o_rd_we_A = s0_vld && s0_q[OFF_RD_WE];
    o_rs_A    = s0_vld ? s0_q[OFF_RS +: 3]   : '0;
    o_rt_A    = s0_vld ? s0_q[OFF_RT +: 3]   : '0;

    o_pc_B    = s1_vld ? s1_q[OFF_PC +: n]   : '0;
    o_insn_B  = s1_vld ? s1_q[OFF_INSN +: n] : '0;
    o_rd_B    = s1_vld ? s1_q[OFF_RD +: 3]   : '0;
    o_rd_we_B = s1_vld && s1_q[OFF_RD_WE];
    o_rs_B    = s1_vld ? s1_q[OFF_RS +: 3]   : '0;
    o_rt_B    = s1_vld ? s1_q[OFF_RT +: 3]   : '0;

    o_dbg_state    = state_q;
    o_dbg_conflict = reason;
    o_dbg_flags    = {s0_q[OFF_RS_RE], s0_q[OFF_RT_RE], s0_q[OFF_RD_WE],
                      s0_q[OFF_IS_MEM], s0_q[OFF_IS_BR],
                      s1_q[OFF_RS_RE], s1_q[OFF_RT_RE], s1_q[OFF_RD_WE],
                      s1_q[OFF_IS_MEM], s1_q[OFF_IS_BR]};
  end

`ifdef LC4_SS_STATS_EN
  // Saturating counters. A split is counted on the cycle S0 issues alone
  // out of a conflicting pair (same stall qualification as a pair issue).
  logic [STAT_W-1:0] pair_cnt_q, pair_cnt_d;
  logic [STAT_W-1:0] split_cnt_q, split_cnt_d;

  always_comb begin
    pair_cnt_d  = pair_cnt_q;
    split_cnt_d = split_cnt_q;
    if (gwe && o_issue_valid_A && o_issue_valid_B && !(&pair_cnt_q))
      pair_cnt_d = pair_cnt_q + STAT_W'(1);
    if (gwe && pair_conflict && !i_stall && !(&split_cnt_q))
      split_cnt_d = split_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_cnt_q  <= '0;
      split_cnt_q <= '0;
    end else begin
      pair_cnt_q  <= pair_cnt_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign o_pair_cnt  = pair_cnt_q;
  assign o_split_cnt = split_cnt_q;
`else
  assign o_pair_cnt  = '0;
  assign o_split_cnt = '0;
`endif

endmodule

// File: tb/tb_lc4_ss_dispatch.sv
// tb_lc4_ss_dispatch: directed scenarios plus randomized traffic for
// lc4_ss_dispatch, checked against an in-order instruction-queue model.
module tb_lc4_ss_dispatch;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] insn;
    logic [2:0]  rs, rt, rd;
    logic        rs_re, rt_re, rd_we, is_mem, is_br;
  } insn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic gwe, i_stall, i_flush;
  always #5 clk = ~clk;

  lc4_ss_dispatch_if #(.n(16)) fif ();

  logic        o_issue_valid_A, o_issue_valid_B;
  logic [15:0] o_pc_A, o_pc_B, o_insn_A, o_insn_B;
  logic [2:0]  o_rd_A, o_rd_B, o_rs_A, o_rt_A, o_rs_B, o_rt_B;
  logic        o_rd_we_A, o_rd_we_B;
  logic [15:0] o_pair_cnt, o_split_cnt;
  logic [1:0]  o_dbg_state;
  logic [3:0]  o_dbg_conflict;
  logic [9:0]  o_dbg_flags;

  lc4_ss_dispatch #(.n(16), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .gwe(gwe), .fetch(fif.slave),
    .i_stall(i_stall), .i_flush(i_flush),
    .o_issue_valid_A(o_issue_valid_A), .o_issue_valid_B(o_issue_valid_B),
    .o_pc_A(o_pc_A), .o_pc_B(o_pc_B), .o_insn_A(o_insn_A), .o_insn_B(o_insn_B),
    .o_rd_A(o_rd_A), .o_rd_B(o_rd_B), .o_rd_we_A(o_rd_we_A), .o_rd_we_B(o_rd_we_B),
    .o_rs_A(o_rs_A), .o_rt_A(o_rt_A), .o_rs_B(o_rs_B), .o_rt_B(o_rt_B),
    .o_pair_cnt(o_pair_cnt), .o_split_cnt(o_split_cnt),
    .o_dbg_state(o_dbg_state), .o_dbg_conflict(o_dbg_conflict),
    .o_dbg_flags(o_dbg_flags)
  );

  // ---------------- scoreboard / checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: the instructions still waiting to issue, oldest first.
  insn_t mq[$];
  int unsigned m_pair, m_split;
  insn_t zi;

  function automatic bit must_split(input insn_t o, input insn_t y);
    return (y.rs_re && o.rd_we && y.rs == o.rd) ||
           (y.rt_re && o.rd_we && y.rt == o.rd) ||
           (o.is_mem && y.is_mem) || o.is_br;
  endfunction

  // ---------------- driver ----------------
  insn_t drv_a, drv_b;
  logic  drv_valid;

  function automatic insn_t mk(input logic [15:0] pc, input logic [2:0] rd,
                               input logic [2:0] rs, input logic [2:0] rt,
                               input bit we, input bit sre, input bit tre,
                               input bit mem, input bit br);
    insn_t t;
    t.pc = pc; t.insn = pc ^ 16'h5a00; t.rd = rd; t.rs = rs; t.rt = rt;
    t.rd_we = we; t.rs_re = sre; t.rt_re = tre; t.is_mem = mem; t.is_br = br;
    return t;
  endfunction

  function automatic insn_t rnd_insn();
    insn_t t;
    t.pc = 16'($urandom); t.insn = 16'($urandom);
    t.rs = 3'($urandom_range(0, 3)); t.rt = 3'($urandom_range(0, 3));
    t.rd = 3'($urandom_range(0, 3));
    t.rs_re = 1'($urandom_range(0, 1)); t.rt_re = 1'($urandom_range(0, 1));
    t.rd_we = 1'($urandom_range(0, 1));
    t.is_mem = ($urandom_range(0, 3) == 0);
    t.is_br  = ($urandom_range(0, 6) == 0);
    return t;
  endfunction

  task automatic apply();
    fif.i_valid   = drv_valid;
    fif.i_pc_A    = drv_a.pc;    fif.i_pc_B    = drv_b.pc;
    fif.i_insn_A  = drv_a.insn;  fif.i_insn_B  = drv_b.insn;
    fif.i_rs_A    = drv_a.rs;    fif.i_rs_B    = drv_b.rs;
    fif.i_rt_A    = drv_a.rt;    fif.i_rt_B    = drv_b.rt;
    fif.i_rd_A    = drv_a.rd;    fif.i_rd_B    = drv_b.rd;
    fif.i_rs_re_A = drv_a.rs_re; fif.i_rs_re_B = drv_b.rs_re;
    fif.i_rt_re_A = drv_a.rt_re; fif.i_rt_re_B = drv_b.rt_re;
    fif.i_rd_we_A = drv_a.rd_we; fif.i_rd_we_B = drv_b.rd_we;
    fif.i_is_mem_A = drv_a.is_mem; fif.i_is_mem_B = drv_b.is_mem;
    fif.i_is_br_A  = drv_a.is_br;  fif.i_is_br_B  = drv_b.is_br;
  endtask

  task automatic idle();
    drv_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0; gwe = 1'b1;
    apply();
  endtask

  task automatic offer(input insn_t a, input insn_t b);
    drv_a = a; drv_b = b; drv_valid = 1'b1;
    i_stall = 1'b0; i_flush = 1'b0; gwe = 1'b1;
    apply();
  endtask

  // Compare every output with the model (called mid-cycle, inputs settled).
  task automatic sample();
    insn_t a, b;
    int    sz;
    bit    conf;
    #2;
    sz   = mq.size();
    a    = (sz >= 1) ? mq[0] : zi;
    b    = (sz == 2) ? mq[1] : zi;
    conf = (sz == 2) && must_split(a, b);
    chk("valid_A", 32'(o_issue_valid_A), 32'(sz >= 1 && !i_stall));
    chk("valid_B", 32'(o_issue_valid_B), 32'(sz == 2 && !conf && !i_stall));
    chk("ready",   32'(fif.o_ready),     32'(!i_stall && !i_flush && !conf));
    chk("rs_A", 32'(o_rs_A), 32'(a.rs));   chk("rt_A", 32'(o_rt_A), 32'(a.rt));
    chk("rs_B", 32'(o_rs_B), 32'(b.rs));   chk("rt_B", 32'(o_rt_B), 32'(b.rt));
    chk("pc_A", 32'(o_pc_A), 32'(a.pc));   chk("pc_B", 32'(o_pc_B), 32'(b.pc));
    chk("insn_A", 32'(o_insn_A), 32'(a.insn));
    chk("insn_B", 32'(o_insn_B), 32'(b.insn));
    chk("rd_A", 32'(o_rd_A), 32'(a.rd));   chk("rd_B", 32'(o_rd_B), 32'(b.rd));
    chk("rd_we_A", 32'(o_rd_we_A), 32'(a.rd_we));
    chk("rd_we_B", 32'(o_rd_we_B), 32'(b.rd_we));
`ifdef LC4_SS_STATS_EN
    chk("pair_cnt",  32'(o_pair_cnt),  m_pair);
    chk("split_cnt", 32'(o_split_cnt), m_split);
`else
    chk("pair_cnt",  32'(o_pair_cnt),  0);
    chk("split_cnt", 32'(o_split_cnt), 0);
`endif
  endtask

  // Model update for the clock edge just taken, using this cycle's inputs.
  task automatic model_update();
    bit conf;
    if (!gwe) return;
    conf = (mq.size() == 2) && must_split(mq[0], mq[1]);
    if (!i_stall && mq.size() == 2 && !conf && m_pair < 32'hffff) m_pair++;
    if (!i_stall && conf && m_split < 32'hffff) m_split++;
    if (i_flush) mq.delete();
    else if (!i_stall) begin
      if (conf) void'(mq.pop_front());
      else begin
        mq.delete();
        if (drv_valid) begin mq.push_back(drv_a); mq.push_back(drv_b); end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  // Short asynchronous reset pulse between edges, checked while low.
  task automatic rst_pulse();
    idle();
    #1 rst = 1'b0;
    #1;
    chk("rst_valid_A", 32'(o_issue_valid_A), 0);
    chk("rst_valid_B", 32'(o_issue_valid_B), 0);
    chk("rst_ready",   32'(fif.o_ready), 1);
    chk("rst_sel", 32'({o_rs_A, o_rt_A, o_rs_B, o_rt_B}), 0);
    chk("rst_cnt", 32'({o_pair_cnt, o_split_cnt}), 0);
    mq.delete(); m_pair = 0; m_split = 0;
    #1 rst = 1'b1;
    advance();
  endtask

  // ---------------- stimulus ----------------
  insn_t add_a, add_b, raw_a, raw_b, ldr, str_i, nxt_a, nxt_b;

  initial begin
    zi = mk(16'h0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0);
    zi.insn = 16'h0;
    drv_a = zi; drv_b = zi;
    rst = 1'b0;
    idle();
    m_pair = 0; m_split = 0;
    repeat (2) @(negedge clk);
    sample();                                       // reset state
    rst = 1'b1;
    @(negedge clk);

    // Independent pair: ADD R1,R2,R3 ; ADD R4,R5,R6
    add_a = mk(16'h0010, 3'd1, 3'd2, 3'd3, 1, 1, 1, 0, 0);
    add_b = mk(16'h0011, 3'd4, 3'd5, 3'd6, 1, 1, 1, 0, 0);
    offer(add_a, add_b); step();
    idle(); sample();
    chk("ind_vA", 32'(o_issue_valid_A), 1); chk("ind_vB", 32'(o_issue_valid_B), 1);
    chk("ind_rs_B", 32'(o_rs_B), 5);        chk("ind_rt_B", 32'(o_rt_B), 6);
    chk("ind_ready", 32'(fif.o_ready), 1);
    advance();

    // Reset mid-PAIR
    offer(add_a, add_b); step();
    rst_pulse();
    idle(); step();

    // RAW split: ADD R3,R1,R2 ; ADD R4,R3,R5
    raw_a = mk(16'h0020, 3'd3, 3'd1, 3'd2, 1, 1, 1, 0, 0);
    raw_b = mk(16'h0021, 3'd4, 3'd3, 3'd5, 1, 1, 1, 0, 0);
    nxt_a = mk(16'h0030, 3'd7, 3'd0, 3'd0, 1, 1, 0, 0, 0);
    nxt_b = mk(16'h0031, 3'd6, 3'd1, 3'd2, 1, 1, 1, 0, 0);
    offer(raw_a, raw_b); step();
    idle(); sample();
    chk("raw1_vA", 32'(o_issue_valid_A), 1); chk("raw1_vB", 32'(o_issue_valid_B), 0);
    chk("raw1_ready", 32'(fif.o_ready), 0);
    advance();
    offer(nxt_a, nxt_b); sample();
    chk("raw2_vA", 32'(o_issue_valid_A), 1); chk("raw2_pc_A", 32'(o_pc_A), 32'h0021);
    chk("raw2_ready", 32'(fif.o_ready), 1);
    advance();
    idle(); sample();
    chk("raw3_pc_A", 32'(o_pc_A), 32'h0030); chk("raw3_vB", 32'(o_issue_valid_B), 1);
    advance();

    // Two memory ops from a clean reset: LDR R1,R2 ; STR R4,R5
    rst_pulse();
    ldr   = mk(16'h0040, 3'd1, 3'd2, 3'd0, 1, 1, 0, 1, 0);
    str_i = mk(16'h0041, 3'd0, 3'd5, 3'd4, 0, 1, 1, 1, 0);
    offer(ldr, str_i); step();
    idle(); sample();
    chk("mem1_vB", 32'(o_issue_valid_B), 0); chk("mem1_ready", 32'(fif.o_ready), 0);
    advance();
    idle(); sample();
    chk("mem2_pc_A", 32'(o_pc_A), 32'h0041);
`ifdef LC4_SS_STATS_EN
    chk("mem_split_cnt", 32'(o_split_cnt), 1); chk("mem_pair_cnt", 32'(o_pair_cnt), 0);
`endif
    advance();

    // Stall held 3 cycles in PAIR
    offer(add_a, add_b); step();
    for (int i = 0; i < 3; i++) begin
      idle(); i_stall = 1'b1; sample();
      chk("stall_vA", 32'(o_issue_valid_A), 0); chk("stall_vB", 32'(o_issue_valid_B), 0);
      chk("stall_ready", 32'(fif.o_ready), 0);
      chk("stall_sel", 32'({o_rs_A, o_rt_A, o_rs_B, o_rt_B}), 32'({3'd2, 3'd3, 3'd5, 3'd6}));
      advance();
    end
    idle(); sample();
    chk("unstall_vA", 32'(o_issue_valid_A), 1); chk("unstall_vB", 32'(o_issue_valid_B), 1);
    advance();

    // Flush with a valid offer while in ONE
    offer(raw_a, raw_b); step();
    idle(); step();                                // split -> ONE
    offer(nxt_a, nxt_b); i_flush = 1'b1; step();
    idle(); sample();
    chk("flush_vA", 32'(o_issue_valid_A), 0); chk("flush_vB", 32'(o_issue_valid_B), 0);
    chk("flush_pc_A", 32'(o_pc_A), 0);
    advance();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      drv_a = rnd_insn(); drv_b = rnd_insn();
      drv_valid = ($urandom_range(0, 9) < 7);
      i_stall   = ($urandom_range(0, 9) == 0);
      i_flush   = ($urandom_range(0, 19) == 0);
      gwe       = ($urandom_range(0, 9) != 0);
      apply();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
